// File: rtl/usb_tx_scheduler.sv
// Round-robin scheduler sharing the USB TX byte path between buffered response packets
// and trigger-event packets; EVT_TIMESTAMP_EN adds a 16-bit timestamp to event packets.
module usb_tx_scheduler #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [7:0]  EVT_CODE   = 8'hE0
) (
    input  logic       clk_usb,
    input  logic       reset,
    input  logic       rsp_valid,
    input  logic [7:0] rsp_data,
    input  logic       rsp_last,
    input  logic       evt_valid,
    input  logic [7:0] evt_code,
    output logic       evt_ready,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    input  logic       tx_ready,
    output logic       overflow,
    output logic       busy
);

    localparam int unsigned AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic        GRANT_RSP = 1'b0;
    localparam logic        GRANT_EVT = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RSP     = 3'd1,
        ST_EVT_HDR = 3'd2,
`ifdef EVT_TIMESTAMP_EN
        ST_EVT_PAY = 3'd3,
        ST_EVT_TS0 = 3'd4,
        ST_EVT_TS1 = 3'd5
`else
        ST_EVT_PAY = 3'd3
`endif
    } state_t;

    logic [8:0]    fifo_mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          overflow_r;
    logic          pending_r;
    logic [7:0]    evt_code_r;
    logic          last_grant_r;
    logic          tx_valid_r;
    logic [7:0]    tx_data_r;
    state_t        state_r;
    state_t        state_next_s;

    logic          load_en_s;
    logic          fifo_empty_s;
    logic          fifo_full_s;
    logic [8:0]    head_s;
    logic          push_s;
    logic          accept_s;
    logic          ld_s;
    logic [7:0]    ld_data_s;
    logic          pop_s;
    logic          clr_pend_s;
    logic          grant_s;
    logic          grant_evt_s;

`ifdef EVT_TIMESTAMP_EN
    logic [15:0]   ts_cnt_r;
    logic [15:0]   ts_lat_r;
`endif

    assign load_en_s    = !tx_valid_r || tx_ready;
    assign fifo_empty_s = (count_r == {(AW + 1){1'b0}});
    assign fifo_full_s  = (count_r == FULL_CNT);
    assign head_s       = fifo_mem_r[rd_ptr_r];
    assign push_s       = rsp_valid && !fifo_full_s;
    assign accept_s     = evt_valid && !pending_r;

    assign evt_ready = !pending_r;
    assign tx_valid  = tx_valid_r;
    assign tx_data   = tx_data_r;
    assign overflow  = overflow_r;
    assign busy      = (state_r != ST_IDLE) || !fifo_empty_s || pending_r;

    // Response storage; contents need no reset because count_r gates every read.
    always_ff @(posedge clk_usb) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= {rsp_last, rsp_data};
        end
    end

    // FIFO pointers, occupancy and the sticky drop flag.
    always_ff @(posedge clk_usb) begin
        if (reset) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {(AW + 1){1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            count_r <= count_r + (AW + 1)'(push_s) - (AW + 1)'(pop_s);
            if (rsp_valid && fifo_full_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Event slot: a single latched request held until its packet has been emitted.
    always_ff @(posedge clk_usb) begin
        if (reset) begin
            pending_r  <= 1'b0;
            evt_code_r <= 8'h00;
        end else if (accept_s) begin
            pending_r  <= 1'b1;
            evt_code_r <= evt_code;
        end else if (clr_pend_s) begin
            pending_r  <= 1'b0;
        end
    end

`ifdef EVT_TIMESTAMP_EN
    // Free-running timestamp, sampled alongside the event code on accept.
    always_ff @(posedge clk_usb) begin
        if (reset) begin
            ts_cnt_r <= 16'h0000;
            ts_lat_r <= 16'h0000;
        end else begin
            ts_cnt_r <= ts_cnt_r + 16'h0001;
            if (accept_s) begin
                ts_lat_r <= ts_cnt_r;
            end
        end
    end
`endif

    // State, arbitration history and the output byte register.
    always_ff @(posedge clk_usb) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            last_grant_r <= GRANT_EVT;
            tx_valid_r   <= 1'b0;
            tx_data_r    <= 8'h00;
        end else begin
            state_r <= state_next_s;
            if (grant_s) begin
                last_grant_r <= grant_evt_s ? GRANT_EVT : GRANT_RSP;
            end
            if (load_en_s) begin
                tx_valid_r <= ld_s;
                if (ld_s) begin
                    tx_data_r <= ld_data_s;
                end
            end
        end
    end

    // Next state and byte selection; a packet runs to completion before the next grant.
    always_comb begin
        state_next_s = state_r;
        ld_s         = 1'b0;
        ld_data_s    = 8'h00;
        pop_s        = 1'b0;
        clr_pend_s   = 1'b0;
        grant_s      = 1'b0;
        grant_evt_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // On a tie the side that did not win last time goes first.
                if (!fifo_empty_s && (!pending_r || (last_grant_r == GRANT_EVT))) begin
                    grant_s = 1'b1;
                    if (load_en_s) begin
                        ld_s         = 1'b1;
                        ld_data_s    = head_s[7:0];
                        pop_s        = 1'b1;
                        state_next_s = head_s[8] ? ST_IDLE : ST_RSP;
                    end else begin
                        state_next_s = ST_RSP;
                    end
                end else if (pending_r) begin
                    grant_s     = 1'b1;
                    grant_evt_s = 1'b1;
                    if (load_en_s) begin
                        ld_s         = 1'b1;
                        ld_data_s    = EVT_CODE;
                        state_next_s = ST_EVT_PAY;
                    end else begin
                        state_next_s = ST_EVT_HDR;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RSP: begin
                if (load_en_s && !fifo_empty_s) begin
                    ld_s         = 1'b1;
                    ld_data_s    = head_s[7:0];
                    pop_s        = 1'b1;
                    state_next_s = head_s[8] ? ST_IDLE : ST_RSP;
                end else begin
                    state_next_s = ST_RSP;
                end
            end
            ST_EVT_HDR: begin
                if (load_en_s) begin
                    ld_s         = 1'b1;
                    ld_data_s    = EVT_CODE;
                    state_next_s = ST_EVT_PAY;
                end else begin
                    state_next_s = ST_EVT_HDR;
                end
            end
            ST_EVT_PAY: begin
                if (load_en_s) begin
                    ld_s      = 1'b1;
                    ld_data_s = evt_code_r;
`ifdef EVT_TIMESTAMP_EN
                    state_next_s = ST_EVT_TS0;
`else
                    clr_pend_s   = 1'b1;
                    state_next_s = ST_IDLE;
`endif
                end else begin
                    state_next_s = ST_EVT_PAY;
                end
            end
`ifdef EVT_TIMESTAMP_EN
            ST_EVT_TS0: begin
                if (load_en_s) begin
                    ld_s         = 1'b1;
                    ld_data_s    = ts_lat_r[7:0];
                    state_next_s = ST_EVT_TS1;
                end else begin
                    state_next_s = ST_EVT_TS0;
                end
            end
            ST_EVT_TS1: begin
                if (load_en_s) begin
                    ld_s         = 1'b1;
                    ld_data_s    = ts_lat_r[15:8];
                    clr_pend_s   = 1'b1;
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_EVT_TS1;
                end
            end
`endif
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_usb_tx_scheduler.sv
// Directed and randomized bench for usb_tx_scheduler; transmitted bytes are collected
// and compared with packet-level expectations built from the scheduling rules.
module tb_usb_tx_scheduler;

    localparam int         DEPTH    = 16;
    localparam logic [7:0] EVT_CODE = 8'hE0;
`ifdef EVT_TIMESTAMP_EN
    localparam int         EVT_LEN  = 4;
`else
    localparam int         EVT_LEN  = 2;
`endif

    logic       clk_usb = 1'b0;
    logic       reset = 1'b1;
    logic       rsp_valid = 1'b0;
    logic [7:0] rsp_data = 8'h00;
    logic       rsp_last = 1'b0;
    logic       evt_valid = 1'b0;
    logic [7:0] evt_code = 8'h00;
    logic       evt_ready;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready = 1'b0;
    logic       overflow;
    logic       busy;

    int asrt_cnt = 0;
    int fail_cnt = 0;
    int cyc = 0;
    int since_rst = 0;

    logic [7:0] xq[$];
    int         xt[$];
    logic [7:0] exq[$];
    logic       s_vld;
    logic [7:0] s_dat;

    usb_tx_scheduler #(.FIFO_DEPTH(DEPTH), .EVT_CODE(EVT_CODE)) dut (
        .clk_usb(clk_usb), .reset(reset),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last),
        .evt_valid(evt_valid), .evt_code(evt_code), .evt_ready(evt_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .overflow(overflow), .busy(busy)
    );

    always #5 clk_usb = ~clk_usb;

    // Sample at the falling edge, then let the rising edge consume the driven inputs.
    task automatic tick();
        @(negedge clk_usb);
        s_vld = tx_valid;
        s_dat = tx_data;
        if (tx_valid && tx_ready) begin
            xq.push_back(tx_data);
            xt.push_back(cyc);
        end
        @(posedge clk_usb);
        #1;
        cyc++;
        since_rst++;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        asrt_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rsp_valid = 1'b0;
        rsp_last = 1'b0;
        evt_valid = 1'b0;
        tx_ready = 1'b0;
        ticks(2);
        reset = 1'b0;
        xq.delete();
        xt.delete();
        exq.delete();
        since_rst = 0;
    endtask

    task automatic push(input logic [7:0] d, input logic l);
        rsp_valid = 1'b1;
        rsp_data = d;
        rsp_last = l;
        tick();
        rsp_valid = 1'b0;
        rsp_last = 1'b0;
    endtask

    task automatic add_evt(input logic [7:0] c, input int ts);
        exq.push_back(EVT_CODE);
        exq.push_back(c);
`ifdef EVT_TIMESTAMP_EN
        exq.push_back(ts[7:0]);
        exq.push_back(ts[15:8]);
`endif
    endtask

    task automatic cmp_q(input string tag);
        chk({tag, "_len"}, xq.size(), exq.size());
        for (int i = 0; i < exq.size() && i < xq.size(); i++) begin
            chk(tag, 32'(xq[i]), 32'(exq[i]));
        end
    endtask

    initial begin
        int p;
        int ts;
        logic [7:0] rb[$];
        logic       rl[$];
        logic [7:0] ev_code[$];
        int         ev_ts[$];
        int         pushed;
        int         acc;
        int         idx;
        int         ri;
        int         ei;
        logic       lst;

        // Reset values
        do_reset();
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_evt_ready", 32'(evt_ready), 32'd1);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // Three-byte response with the transmitter always ready
        tx_ready = 1'b1;
        p = cyc;
        push(8'h11, 1'b0);
        push(8'h22, 1'b0);
        push(8'h33, 1'b1);
        ticks(5);
        exq = '{8'h11, 8'h22, 8'h33};
        cmp_q("rsp_bytes");
        chk("rsp_first_cycle", 32'(xt[0]), 32'(p + 2));
        chk("rsp_last_cycle", 32'(xt[2]), 32'(p + 4));
        chk("rsp_busy_after", 32'(busy), 32'd0);

        // Backpressure: first byte must hold while tx_ready is low
        do_reset();
        push(8'h11, 1'b0);
        push(8'h22, 1'b0);
        push(8'h33, 1'b1);
        chk("bp_first", 32'({s_vld, s_dat}), 32'({1'b1, 8'h11}));
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_hold", 32'({s_vld, s_dat}), 32'({1'b1, 8'h11}));
        end
        tx_ready = 1'b1;
        ticks(6);
        exq = '{8'h11, 8'h22, 8'h33};
        cmp_q("bp_bytes");

        // Overflow: an event parked in the output register keeps all 16 entries for responses
        do_reset();
        evt_valid = 1'b1;
        evt_code = 8'h3C;
        ts = since_rst;
        tick();
        evt_valid = 1'b0;
        tick();
        for (int i = 1; i <= 18; i++) begin
            push(8'(i), (i == 16));
            if (i == 16) chk("ovf_at_16", 32'(overflow), 32'd0);
            if (i == 17) chk("ovf_at_17", 32'(overflow), 32'd1);
        end
        tx_ready = 1'b1;
        ticks(30);
        add_evt(8'h3C, ts);
        for (int i = 1; i <= 16; i++) exq.push_back(8'(i));
        cmp_q("ovf_drain");
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // Ties: response first after reset; after a lone response the event wins
        do_reset();
        tx_ready = 1'b1;
        evt_valid = 1'b1;
        evt_code = 8'h5A;
        ts = since_rst;
        rsp_valid = 1'b1;
        rsp_data = 8'hA1;
        tick();
        evt_valid = 1'b0;
        push(8'hA2, 1'b1);
        ticks(8);
        exq.push_back(8'hA1);
        exq.push_back(8'hA2);
        add_evt(8'h5A, ts);
        push(8'hD1, 1'b1);
        ticks(4);
        exq.push_back(8'hD1);
        evt_valid = 1'b1;
        evt_code = 8'h6B;
        ts = since_rst;
        rsp_valid = 1'b1;
        rsp_data = 8'hB1;
        tick();
        evt_valid = 1'b0;
        push(8'hB2, 1'b1);
        ticks(10);
        add_evt(8'h6B, ts);
        exq.push_back(8'hB1);
        exq.push_back(8'hB2);
        cmp_q("tie_order");

        // Atomicity: event raised inside a response gap waits for the last byte
        do_reset();
        tx_ready = 1'b1;
        push(8'hC1, 1'b0);
        push(8'hC2, 1'b0);
        evt_valid = 1'b1;
        evt_code = 8'h77;
        ts = since_rst;
        tick();
        evt_valid = 1'b0;
        ticks(2);
        push(8'hC3, 1'b0);
        push(8'hC4, 1'b1);
        ticks(10);
        exq = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
        add_evt(8'h77, ts);
        cmp_q("atomic");

        // Randomized traffic; response bytes avoid EVT_CODE so packets can be told apart
        do_reset();
        pushed = 0;
        acc = 0;
        for (int n = 0; n < 400; n++) begin
            tx_ready = ($urandom_range(0, 9) < 7);
            if (evt_ready && ($urandom_range(0, 9) == 0)) begin
                evt_valid = 1'b1;
                evt_code = 8'($urandom_range(0, 255));
                ev_code.push_back(evt_code);
                ev_ts.push_back(since_rst);
                acc++;
            end else begin
                evt_valid = 1'b0;
            end
            if (((pushed + EVT_LEN * acc - xq.size()) < 12) && ($urandom_range(0, 1) == 1)) begin
                rsp_valid = 1'b1;
                rsp_data = 8'($urandom_range(0, 223));
                rsp_last = ($urandom_range(0, 3) == 0);
                rb.push_back(rsp_data);
                rl.push_back(rsp_last);
                pushed++;
            end else begin
                rsp_valid = 1'b0;
                rsp_last = 1'b0;
            end
            tick();
        end
        evt_valid = 1'b0;
        rsp_valid = 1'b0;
        if (rl.size() > 0 && !rl[rl.size() - 1]) begin
            rb.push_back(8'h01);
            rl.push_back(1'b1);
            push(8'h01, 1'b1);
        end
        tx_ready = 1'b1;
        ticks(80);
        idx = 0;
        ri = 0;
        ei = 0;
        while (idx < xq.size()) begin
            if (xq[idx] == EVT_CODE) begin
                chk("rnd_evt_code", 32'(xq[idx + 1]), 32'(ev_code[ei]));
`ifdef EVT_TIMESTAMP_EN
                chk("rnd_evt_ts", 32'({xq[idx + 3], xq[idx + 2]}), 32'(ev_ts[ei][15:0]));
`endif
                idx += EVT_LEN;
                ei++;
            end else begin
                lst = 1'b0;
                while (!lst && idx < xq.size()) begin
                    chk("rnd_rsp", 32'(xq[idx]), 32'(rb[ri]));
                    lst = rl[ri];
                    ri++;
                    idx++;
                end
            end
        end
        chk("rnd_rsp_count", 32'(ri), 32'(rb.size()));
        chk("rnd_evt_count", 32'(ei), 32'(ev_code.size()));
        chk("rnd_no_overflow", 32'(overflow), 32'd0);
        chk("rnd_idle", 32'(busy), 32'd0);

`ifdef EVT_TIMESTAMP_EN
        // Timestamped event accepted while the counter reads 16'h1234
        do_reset();
        tx_ready = 1'b1;
        while (since_rst != 16'h1234) tick();
        evt_valid = 1'b1;
        evt_code = 8'h07;
        tick();
        evt_valid = 1'b0;
        ticks(3);
        chk("ts_ready_low", 32'(evt_ready), 32'd0);
        tick();
        chk("ts_ready_back", 32'(evt_ready), 32'd1);
        ticks(3);
        exq = '{8'hE0, 8'h07, 8'h34, 8'h12};
        cmp_q("ts_bytes");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", asrt_cnt, fail_cnt);
        $finish;
    end

endmodule
